if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 18 +
 rtl/if_id_reg.sv | 49 ++++
 rtl/if_stage.sv | 120 ++++++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline constants and fetch FSM encoding
//
// Contents:
//   fetch_state_e : fetch FSM states (BOOT, RUN, HALT)
//   RV_NOP        : canonical bubble instruction, addi x0,x0,0
//   PC_INCR       : sequential fetch increment in bytes
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RV_NOP  = 32'h0000_0013;
    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and bubble controls
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   hold              : keep every field unchanged
//   bubble            : load NOP with valid=0, keep pc/pc4 (wins over hold)
//   fetch_pc/pc4/instr: values captured on a normal load
//   if_id_pc/pc4/instr/valid : registered outputs
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [31:0]      NOP_INSTR    = RV_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            bubble,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [XLEN-1:0] fetch_pc4,
    input  logic [31:0]     fetch_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INCR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_pc    <= RESET_VECTOR;
            if_id_pc4   <= RESET_VECTOR + PC_STEP;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (bubble) begin
            // pc/pc4 deliberately keep their old values
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (!hold) begin
            if_id_pc    <= fetch_pc;
            if_id_pc4   <= fetch_pc4;
            if_id_instr <= fetch_instr;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch FSM and IF/ID register
//
// Ports:
//   clk, rst                   : clock, asynchronous active-low reset
//   stall_i                    : hold PC and IF/ID
//   redirect_i, redirect_pc_i  : taken branch/jump, flushes IF/ID (beats stall)
//   halt_i                     : stop fetching, enter HALT until reset
//   imem_addr_o, imem_rdata_i  : combinational-read instruction memory
//   if_id_pc_o/pc4_o/instr_o/valid_o : IF/ID register outputs
//   misalign_o                 : sticky, redirect target had bits[1:0] != 0
//   halted_o                   : FSM is in HALT
module if_stage
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [31:0]      NOP_INSTR    = RV_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o,
    output logic            if_id_valid_o,
    output logic            misalign_o,
    output logic            halted_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INCR);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_q, misalign_d;
    logic            ifid_hold, ifid_bubble;

    assign pc_plus4 = pc_q + PC_STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        misalign_d  = misalign_q;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        case (state_q)
            ST_BOOT: begin
                // one settling edge: PC stays at the reset vector
                state_d     = ST_RUN;
                ifid_bubble = 1'b1;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    pc_d        = {redirect_pc_i[XLEN-1:2], 2'b00};
                    ifid_bubble = 1'b1;
                    if (redirect_pc_i[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end else if (halt_i) begin
                    // freeze PC at the halting fetch and start draining IF/ID
                    ifid_bubble = 1'b1;
                end else if (stall_i) begin
                    ifid_hold = 1'b1;
                end else begin
                    pc_d = pc_plus4;
                end
                if (halt_i) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_d     = ST_BOOT;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR),
        .NOP_INSTR    (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .hold        (ifid_hold),
        .bubble      (ifid_bubble),
        .fetch_pc    (pc_q),
        .fetch_pc4   (pc_plus4),
        .fetch_instr (imem_rdata_i),
        .if_id_pc    (if_id_pc_o),
        .if_id_pc4   (if_id_pc4_o),
        .if_id_instr (if_id_instr_o),
        .if_id_valid (if_id_valid_o)
    );

    assign imem_addr_o = pc_q;
    assign misalign_o  = misalign_q;
    assign halted_o    = (state_q == ST_HALT);

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        halt_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        misalign_o;
    logic        halted_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_valid_o (if_id_valid_o),
        .misalign_o    (misalign_o),
        .halted_o      (halted_o)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0050_0093;
        return 32'hA500_0000 ^ addr;
    endfunction

    assign imem_rdata_i = imem_word(imem_addr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},   imem_addr_o, 32'h0);
        check({tag, "_pc"},     if_id_pc_o, 32'h0);
        check({tag, "_pc4"},    if_id_pc4_o, 32'h4);
        check({tag, "_instr"},  if_id_instr_o, NOP);
        check({tag, "_valid"},  {31'b0, if_id_valid_o}, 32'h0);
        check({tag, "_misal"},  {31'b0, misalign_o}, 32'h0);
        check({tag, "_halted"}, {31'b0, halted_o}, 32'h0);
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1 check_reset_outputs("rst0");
        @(posedge clk);
        #1 rst = 1'b1;

        // BOOT edge: still bubble, PC at reset vector
        step();
        check("boot_addr",  imem_addr_o, 32'h0);
        check("boot_valid", {31'b0, if_id_valid_o}, 32'h0);
        check("boot_instr", if_id_instr_o, NOP);

        // first fetch
        step();
        check("f0_pc",    if_id_pc_o, 32'h0);
        check("f0_pc4",   if_id_pc4_o, 32'h4);
        check("f0_instr", if_id_instr_o, 32'h0050_0093);
        check("f0_valid", {31'b0, if_id_valid_o}, 32'h1);
        check("f0_addr",  imem_addr_o, 32'h4);

        step();
        check("f1_addr",  imem_addr_o, 32'h8);
        check("f1_pc",    if_id_pc_o, 32'h4);
        check("f1_instr", if_id_instr_o, 32'hA500_0004);

        // stall three cycles at PC=8
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  imem_addr_o, 32'h8);
            check("stall_pc",    if_id_pc_o, 32'h4);
            check("stall_instr", if_id_instr_o, 32'hA500_0004);
            check("stall_valid", {31'b0, if_id_valid_o}, 32'h1);
        end
        stall_i = 1'b0;
        step();
        check("unstall_addr",  imem_addr_o, 32'hC);
        check("unstall_pc",    if_id_pc_o, 32'h8);
        check("unstall_instr", if_id_instr_o, 32'hA500_0008);

        // redirect beats stall
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0; stall_i = 1'b0;
        check("redir_addr",  imem_addr_o, 32'h40);
        check("redir_valid", {31'b0, if_id_valid_o}, 32'h0);
        check("redir_instr", if_id_instr_o, NOP);
        check("redir_pc",    if_id_pc_o, 32'h8);
        check("redir_pc4",   if_id_pc4_o, 32'hC);
        check("redir_misal", {31'b0, misalign_o}, 32'h0);
        step();
        check("redir2_pc",    if_id_pc_o, 32'h40);
        check("redir2_instr", if_id_instr_o, 32'hA500_0040);
        check("redir2_valid", {31'b0, if_id_valid_o}, 32'h1);
        check("redir2_addr",  imem_addr_o, 32'h44);

        // misaligned redirect
        redirect_i = 1'b1; redirect_pc_i = 32'h42;
        step();
        redirect_i = 1'b0;
        check("mis_addr",  imem_addr_o, 32'h40);
        check("mis_flag",  {31'b0, misalign_o}, 32'h1);
        repeat (10) step();
        check("mis_sticky", {31'b0, misalign_o}, 32'h1);
        check("mis_addr10", imem_addr_o, 32'h68);

        // halt at PC=0x10
        redirect_i = 1'b1; redirect_pc_i = 32'h10;
        step();
        redirect_i = 1'b0;
        check("pre_halt_addr", imem_addr_o, 32'h10);
        step();
        check("pre_halt_valid", {31'b0, if_id_valid_o}, 32'h1);
        check("pre_halt_addr2", imem_addr_o, 32'h14);
        redirect_i = 1'b1; redirect_pc_i = 32'h10;
        step();
        redirect_i = 1'b0;
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        check("halt_flag",  {31'b0, halted_o}, 32'h1);
        check("halt_addr",  imem_addr_o, 32'h10);
        check("halt_valid", {31'b0, if_id_valid_o}, 32'h0);
        check("halt_instr", if_id_instr_o, NOP);
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h80;
        step();
        step();
        redirect_i = 1'b0; stall_i = 1'b0;
        check("halt_ign_addr",  imem_addr_o, 32'h10);
        check("halt_ign_flag",  {31'b0, halted_o}, 32'h1);
        check("halt_ign_valid", {31'b0, if_id_valid_o}, 32'h0);

        // async reset out of HALT clears everything including misalign
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_halt");
        #1 rst = 1'b1;
        step();
        for (int i = 0; i < 9; i++) step();
        check("run24_addr", imem_addr_o, 32'h24);
        check("run24_pc",   if_id_pc_o, 32'h20);

        // reset between edges with a redirect and stall pending
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h80;
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        redirect_i = 1'b0; stall_i = 1'b0;
        #1 rst = 1'b1;
        step();
        check("rst_boot_addr", imem_addr_o, 32'h0);
        step();
        check("rst_f0_pc",    if_id_pc_o, 32'h0);
        check("rst_f0_instr", if_id_instr_o, 32'h0050_0093);
        check("rst_f0_addr",  imem_addr_o, 32'h4);

        // PC wrap at the top of the address space
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        check("wrap_top", imem_addr_o, 32'hFFFF_FFFC);
        step();
        check("wrap_addr",  imem_addr_o, 32'h0);
        check("wrap_pc",    if_id_pc_o, 32'hFFFF_FFFC);
        check("wrap_pc4",   if_id_pc4_o, 32'h0);
        check("wrap_misal", {31'b0, misalign_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
